registro_id_ex: RTL and testbench

- Pipeline register between decode and execute, plus operand forwarding; feeds the ULA (operand inputs entrada1/entrada2, ALUControl input).
- Captures decoded operands/control each cycle; supports stall (hold) and flush (bubble).
- Resolves RAW hazards by selecting EX/MEM or MEM/WB results in place of stale register-file data.

---
 rtl/registro_id_ex_pkg.sv | 10 +
 rtl/registro_id_ex_unidade_forwarding.sv | 26 ++
 rtl/registro_id_ex.sv | 87 ++++++++
 tb/tb_registro_id_ex.sv | 137 +++++++++++++
 4 files changed

// File: rtl/registro_id_ex_pkg.sv
// registro_id_ex_pkg: shared widths, forwarding codes and bubble values for the ID/EX stage.
package registro_id_ex_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CTRL_WIDTH     = 3;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [CTRL_WIDTH-1:0] ALU_BUBBLE = 3'b000;
endpackage

// File: rtl/registro_id_ex_unidade_forwarding.sv
// unidade_forwarding: picks the freshest value for one source register (EX/MEM over MEM/WB over regfile).
module unidade_forwarding
  import registro_id_ex_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = REG_ADDR_WIDTH
) (
  input  logic [AW-1:0] rs,
  input  logic [DW-1:0] dado,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_resultado,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_dado,
  output logic [DW-1:0] valor,
  output logic [1:0]    codigo
);
  logic hit_exmem, hit_memwb;
  always_comb begin
    hit_exmem = exmem_reg_write && exmem_rd != '0 && exmem_rd == rs;
    hit_memwb = memwb_reg_write && memwb_rd != '0 && memwb_rd == rs;
    codigo    = hit_exmem ? FWD_EXMEM : hit_memwb ? FWD_MEMWB : FWD_REG;
    valor     = hit_exmem ? exmem_resultado : hit_memwb ? memwb_dado : dado;
  end
endmodule

// File: rtl/registro_id_ex.sv
// registro_id_ex: ID/EX pipeline register with stall/flush and operand forwarding into the ULA.
module registro_id_ex
  import registro_id_ex_pkg::*;
#(
  parameter int DATA_WIDTH     = registro_id_ex_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = registro_id_ex_pkg::REG_ADDR_WIDTH,
  parameter int CTRL_WIDTH     = registro_id_ex_pkg::CTRL_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      id_valido,
  input  logic [DATA_WIDTH-1:0]     id_dado1,
  input  logic [DATA_WIDTH-1:0]     id_dado2,
  input  logic [DATA_WIDTH-1:0]     id_imediato,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_alu_src,
  input  logic [CTRL_WIDTH-1:0]     id_ALUControl,
  input  logic                      id_reg_write,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_resultado,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_dado,
  output logic [DATA_WIDTH-1:0]     entrada1,
  output logic [DATA_WIDTH-1:0]     entrada2,
  output logic [CTRL_WIDTH-1:0]     ALUControl,
  output logic                      ex_valido,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic [DATA_WIDTH-1:0]     ex_dado_store,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b
);
  logic [DATA_WIDTH-1:0]     dado1, dado2, imediato, val_a, val_b;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2;
  logic                      alu_src;
  logic [1:0]                cod_a, cod_b;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n || flush) begin
      ex_valido    <= 1'b0;
      dado1        <= '0;
      dado2        <= '0;
      imediato     <= '0;
      rs1          <= '0;
      rs2          <= '0;
      ex_rd        <= '0;
      alu_src      <= 1'b0;
      ALUControl   <= ALU_BUBBLE;
      ex_reg_write <= 1'b0;
    end else if (!stall) begin
      ex_valido    <= id_valido;
      dado1        <= id_dado1;
      dado2        <= id_dado2;
      imediato     <= id_imediato;
      rs1          <= id_rs1;
      rs2          <= id_rs2;
      ex_rd        <= id_rd;
      alu_src      <= id_alu_src;
      ALUControl   <= id_ALUControl;
      ex_reg_write <= id_reg_write && id_valido;
    end
  unidade_forwarding #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_fwd_a (
    .rs(rs1), .dado(dado1),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_resultado(exmem_resultado),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_dado(memwb_dado),
    .valor(val_a), .codigo(cod_a)
  );
  unidade_forwarding #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_fwd_b (
    .rs(rs2), .dado(dado2),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_resultado(exmem_resultado),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_dado(memwb_dado),
    .valor(val_b), .codigo(cod_b)
  );
  // An invalid slot may still hold captured data; keep it away from the ULA.
  always_comb begin
    entrada1      = ex_valido ? val_a : '0;
    entrada2      = !ex_valido ? '0 : alu_src ? imediato : val_b;
    ex_dado_store = ex_valido ? val_b : '0;
    fwd_a         = ex_valido ? cod_a : FWD_REG;
    fwd_b         = ex_valido ? cod_b : FWD_REG;
  end
endmodule

// File: tb/tb_registro_id_ex.sv
// tb_registro_id_ex: directed checks of load, reset, forwarding, immediate select, stall and flush.
module tb_registro_id_ex;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic        id_valido = 0, id_alu_src = 0, id_reg_write = 0, stall = 0, flush = 0;
  logic [31:0] id_dado1 = 0, id_dado2 = 0, id_imediato = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [2:0]  id_ALUControl = 0;
  logic        exmem_reg_write = 0, memwb_reg_write = 0;
  logic [4:0]  exmem_rd = 0, memwb_rd = 0;
  logic [31:0] exmem_resultado = 0, memwb_dado = 0;
  logic [31:0] entrada1, entrada2, ex_dado_store;
  logic [2:0]  ALUControl;
  logic        ex_valido, ex_reg_write;
  logic [4:0]  ex_rd;
  logic [1:0]  fwd_a, fwd_b;
  int          errors = 0, checks = 0;
  registro_id_ex dut (
    .clock(clock), .reset_n(reset_n), .id_valido(id_valido), .id_dado1(id_dado1), .id_dado2(id_dado2),
    .id_imediato(id_imediato), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_ALUControl(id_ALUControl), .id_reg_write(id_reg_write), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_resultado(exmem_resultado),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_dado(memwb_dado),
    .entrada1(entrada1), .entrada2(entrada2), .ALUControl(ALUControl), .ex_valido(ex_valido),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_dado_store(ex_dado_store), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] d1, d2, imm, input logic [4:0] r1, r2, rd,
                       input logic src, input logic [2:0] alu, input logic rw);
    {id_valido, id_dado1, id_dado2, id_imediato} = {v, d1, d2, imm};
    {id_rs1, id_rs2, id_rd, id_alu_src, id_ALUControl, id_reg_write} = {r1, r2, rd, src, alu, rw};
  endtask
  task automatic fwd_in(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                        input logic mw, input logic [4:0] mr, input logic [31:0] md);
    {exmem_reg_write, exmem_rd, exmem_resultado} = {ew, er, ed};
    {memwb_reg_write, memwb_rd, memwb_dado} = {mw, mr, md};
  endtask
  task automatic step;
    @(posedge clock);
    #2;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_e1"}, entrada1, 0);
    check({tag, "_e2"}, entrada2, 0);
    check({tag, "_st"}, ex_dado_store, 0);
    check({tag, "_alu"}, {29'd0, ALUControl}, 0);
    check({tag, "_vld"}, {31'd0, ex_valido}, 0);
    check({tag, "_rd"}, {27'd0, ex_rd}, 0);
    check({tag, "_rw"}, {31'd0, ex_reg_write}, 0);
    check({tag, "_fwd"}, {28'd0, fwd_a, fwd_b}, 0);
  endtask
  initial begin
    #12;
    check_zero("rst_init");
    reset_n = 1;
    drive(1, 32'h77, 32'h66, 32'h55, 5'd4, 5'd6, 5'd8, 0, 3'b111, 1);
    step();
    check("pre_rst_e1", entrada1, 32'h77);
    #2 reset_n = 0;
    #1 check_zero("rst_mid");
    #2 reset_n = 1;
    drive(1, 32'd3, 32'd1, 32'd0, 5'd1, 5'd2, 5'd3, 0, 3'b011, 1);
    step();
    check("load_e1", entrada1, 32'd3);
    check("load_e2", entrada2, 32'd1);
    check("load_alu", {29'd0, ALUControl}, 32'd3);
    check("load_fwd", {28'd0, fwd_a, fwd_b}, 0);
    check("load_vld", {31'd0, ex_valido}, 1);
    check("load_rd", {27'd0, ex_rd}, 32'd3);
    check("load_rw", {31'd0, ex_reg_write}, 1);
    check("load_st", ex_dado_store, 32'd1);
    drive(1, 32'h11, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 0, 3'b010, 1);
    step();
    fwd_in(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
    #1 check("exmem_e1", entrada1, 32'hAA);
    check("exmem_fa", {30'd0, fwd_a}, 2);
    fwd_in(0, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
    #1 check("memwb_a_e1", entrada1, 32'hBB);
    check("memwb_a_fa", {30'd0, fwd_a}, 1);
    fwd_in(0, 5'd5, 32'hAA, 0, 5'd5, 32'hBB);
    #1 check("reg_a_e1", entrada1, 32'h11);
    drive(1, 32'h22, 32'h33, 32'h0, 5'd0, 5'd7, 5'd1, 0, 3'b001, 1);
    step();
    fwd_in(1, 5'd0, 32'hAA, 1, 5'd7, 32'd9);
    #1 check("memwb_e2", entrada2, 32'd9);
    check("memwb_fb", {30'd0, fwd_b}, 1);
    check("r0_fa", {30'd0, fwd_a}, 0);
    check("r0_e1", entrada1, 32'h22);
    drive(1, 32'h0, 32'h33, 32'hFFFFFFFC, 5'd0, 5'd7, 5'd2, 1, 3'b000, 1);
    fwd_in(0, 5'd0, 0, 1, 5'd7, 32'd4);
    step();
    check("imm_e2", entrada2, 32'hFFFFFFFC);
    check("imm_st", ex_dado_store, 32'd4);
    check("imm_fb", {30'd0, fwd_b}, 1);
    fwd_in(0, 0, 0, 0, 0, 0);
    drive(1, 32'h44, 32'h0, 32'h0, 5'd1, 5'd0, 5'd9, 0, 3'b101, 1);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 32'h100 + i, 32'h200, 32'h300, 5'd10 + 5'(i), 5'd11, 5'd12 + 5'(i), 1, 3'(i), 0);
      step();
      check("stall_rd", {27'd0, ex_rd}, 32'd9);
      check("stall_alu", {29'd0, ALUControl}, 32'd5);
      check("stall_e1", entrada1, 32'h44);
      check("stall_rw", {31'd0, ex_reg_write}, 1);
    end
    fwd_in(1, 5'd1, 32'hCC, 0, 0, 0);
    #1 check("stall_fwd_e1", entrada1, 32'hCC);
    check("stall_fwd_fa", {30'd0, fwd_a}, 2);
    flush = 1;
    drive(1, 32'h1, 32'h2, 32'h3, 5'd1, 5'd1, 5'd1, 0, 3'b110, 1);
    step();
    check_zero("flush");
    {stall, flush} = 2'b00;
    drive(0, 32'h55, 32'h66, 32'h0, 5'd1, 5'd2, 5'd3, 0, 3'b100, 1);
    step();
    check("inv_rw", {31'd0, ex_reg_write}, 0);
    check("inv_vld", {31'd0, ex_valido}, 0);
    check("inv_e1", entrada1, 0);
    check("inv_fa", {30'd0, fwd_a}, 0);
    fwd_in(0, 0, 0, 0, 0, 0);
    drive(1, 32'h99, 32'h88, 32'h0, 5'd3, 5'd4, 5'd5, 0, 3'b010, 1);
    step();
    check("pre_rst2_e1", entrada1, 32'h99);
    stall = 1;
    #2 reset_n = 0;
    #1 check_zero("rst_stall");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
